// File: rtl/rv32i_multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over one shared ALU and one unified memory, and counts retired instructions.
module rv32i_multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_instret;
  logic             w_retire;
  logic [1:0]       w_alu_op;
  logic             w_mem_req;
  logic             w_mem_write;
  logic             w_ir_write;
  logic             w_pc_write;
  logic             w_reg_write;
  logic             w_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // An instruction retires on the edge that leaves its final state.
  assign w_retire = (r_state == S_MEMWB) | (r_state == S_ALUWB) | (r_state == S_BEQ) |
                    ((r_state == S_MEMWRITE) & mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + CNT_W'(1);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    w_alu_op    = 2'b00;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b01;
        w_illegal = !(opcode inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        AdrSrc    = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        AdrSrc      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA  = 2'b10;
        w_alu_op = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        w_alu_op = 2'b10;
      end
      S_ALUWB:    w_reg_write = 1'b1;
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        w_alu_op   = 2'b01;
        w_pc_write = zero;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        w_pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (w_alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (opcode[5] & funct7_5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Write/request strobes are held low for the whole time reset is asserted.
  assign mem_req       = w_mem_req   & rst_n;
  assign MemWrite      = w_mem_write & rst_n;
  assign IRWrite       = w_ir_write  & rst_n;
  assign PCWrite       = w_pc_write  & rst_n;
  assign RegWrite      = w_reg_write & rst_n;
  assign illegal_instr = w_illegal   & rst_n;
  assign instret       = r_instret;
  assign state_o       = r_state;
endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// Self-checking bench: per-instruction phase-list model of the controller,
// directed scenarios with literal expectations, then randomized instruction mix.
module tb_rv32i_multicycle_controller;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       opcode = 7'h0;
  logic [2:0]       funct3 = 3'h0;
  logic             funct7_5 = 1'b0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b1;
  logic             mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, illegal_instr;
  logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]       ALUControl;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state_o;

  always #5 clk = ~clk;

  rv32i_multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal_instr(illegal_instr), .instret(instret),
    .state_o(state_o)
  );

  // Debug encoding of state_o chosen by the design.
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4;
  localparam int P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BEQ = 9, P_JAL = 10;
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

  typedef struct packed {
    logic       mem_req, adr, mw, irw, pcw, rw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] aluc;
    logic       ill;
  } ctl_t;

  int total = 0;
  int bad = 0;
  int cur = P_FETCH;
  int ph_q[$];
  int kind = K_ILL;
  int cyc, stalls, last_cyc;
  logic [CNT_W-1:0] m_instret = '0;
  int nominal [7] = '{5, 4, 4, 4, 3, 4, 2};
  logic [6:0] ill_ops [5] = '{7'h7f, 7'h37, 7'h17, 7'h67, 7'h00};
  logic [2:0] cap_aluc;
  logic       cap_pcw;
  logic [1:0] cap_imm;
  int         cap_rw, cap_ill;
  int         ncyc;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] alu_fn();
    case (funct3)
      3'b000:  return (kind == K_R && funct7_5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic ctl_t expect_ctl(int ph);
    ctl_t c = '0;
    c.imm = (kind == K_SW) ? 2'b01 : (kind == K_BEQ) ? 2'b10 : (kind == K_JAL) ? 2'b11 : 2'b00;
    case (ph)
      P_FETCH:    begin c.mem_req = 1; c.sb = 2; c.rs = 2; c.irw = mem_ready; c.pcw = mem_ready; end
      P_DECODE:   begin c.sa = 1; c.sb = 1; c.ill = (kind == K_ILL); end
      P_MEMADR:   begin c.sa = 2; c.sb = 1; end
      P_MEMREAD:  begin c.mem_req = 1; c.adr = 1; end
      P_MEMWB:    begin c.rs = 1; c.rw = 1; end
      P_MEMWRITE: begin c.mem_req = 1; c.adr = 1; c.mw = 1; end
      P_EXECR:    begin c.sa = 2; c.aluc = alu_fn(); end
      P_EXECI:    begin c.sa = 2; c.sb = 1; c.aluc = alu_fn(); end
      P_ALUWB:    c.rw = 1;
      P_BEQ:      begin c.sa = 2; c.aluc = 3'b001; c.pcw = zero; end
      P_JAL:      begin c.sa = 1; c.sb = 2; c.pcw = 1; end
      default:    ;
    endcase
    return c;
  endfunction

  task automatic start_instr(int k, logic [2:0] f3, logic f7, logic [6:0] ill);
    kind = k; funct3 = f3; funct7_5 = f7; cyc = 0; stalls = 0;
    cap_aluc = 3'bx; cap_pcw = 1'bx; cap_imm = 2'bx; cap_rw = 0; cap_ill = 0;
    ph_q.delete();
    case (k)
      K_LW:    begin opcode = 7'b0000011; ph_q = '{P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB}; end
      K_SW:    begin opcode = 7'b0100011; ph_q = '{P_DECODE, P_MEMADR, P_MEMWRITE}; end
      K_R:     begin opcode = 7'b0110011; ph_q = '{P_DECODE, P_EXECR, P_ALUWB}; end
      K_I:     begin opcode = 7'b0010011; ph_q = '{P_DECODE, P_EXECI, P_ALUWB}; end
      K_BEQ:   begin opcode = 7'b1100011; ph_q = '{P_DECODE, P_BEQ}; end
      K_JAL:   begin opcode = 7'b1101111; ph_q = '{P_DECODE, P_JAL, P_ALUWB}; end
      default: begin opcode = ill;        ph_q = '{P_DECODE}; end
    endcase
  endtask

  // Called with inputs already driven for this cycle; compares, then advances the model.
  task automatic tick();
    ctl_t e;
    logic [17:0] a;
    int nxt;
    logic inc;
    #2;
    e = expect_ctl(cur);
    a = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA,
         ALUSrcB, ImmSrc, ALUControl, illegal_instr};
    chk("ctl", 32'(a), 32'(e));
    chk("state", 32'(state_o), cur);
    chk("instret", instret, m_instret);
    if (cur == P_EXECR || cur == P_EXECI) cap_aluc = ALUControl;
    if (cur == P_BEQ) begin cap_pcw = PCWrite; cap_aluc = ALUControl; end
    if (RegWrite) cap_rw++;
    if (illegal_instr) cap_ill++;
    cap_imm = ImmSrc;
    cyc++;
    inc = 1'b0;
    if ((cur == P_FETCH || cur == P_MEMREAD || cur == P_MEMWRITE) && !mem_ready) begin
      stalls++;
      nxt = cur;
    end else if (ph_q.size() != 0) begin
      nxt = ph_q.pop_front();
    end else begin
      nxt = P_FETCH;
      inc = (kind != K_ILL);
      chk("cycles", cyc, nominal[kind] + stalls);
      last_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cur = nxt;
    if (inc) m_instret = m_instret + 1;
  endtask

  task automatic run_instr(int k, logic [2:0] f3, logic f7, logic z, bit rnd, int st,
                           logic [6:0] ill, output int n);
    int guard = 0;
    int left = st;
    start_instr(k, f3, f7, ill);
    do begin
      if (rnd) mem_ready = ($urandom_range(0, 3) != 0);
      else if ((cur == P_MEMREAD || cur == P_MEMWRITE) && left > 0) begin
        mem_ready = 1'b0;
        left--;
      end else mem_ready = 1'b1;
      zero = rnd ? 1'($urandom_range(0, 1)) : z;
      tick();
      guard++;
    end while (!(cur == P_FETCH && ph_q.size() == 0) && guard < 200);
    if (guard >= 200) begin
      total++; bad++;
      $display("FAIL timeout: instruction kind %0d never returned to fetch", k);
    end
    n = last_cyc;
    $display("instr kind=%0d op=%b f3=%b f7=%0d cycles=%0d instret=%0d",
             k, opcode, funct3, funct7_5, n, instret);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: strobes forced low even though the state is FETCH with mem_ready high.
    #12;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_irwrite", 32'(IRWrite), 0);
    chk("rst_pcwrite", 32'(PCWrite), 0);
    chk("rst_state", 32'(state_o), P_FETCH);
    chk("rst_instret", instret, 0);
    @(negedge clk);
    rst_n = 1'b1;
    opcode = 7'b0110011;
    #1;
    chk("fetch_mem_req", 32'(mem_req), 1);
    chk("fetch_irwrite", 32'(IRWrite), 1);
    chk("fetch_pcwrite", 32'(PCWrite), 1);
    chk("fetch_alusrcb", 32'(ALUSrcB), 2);
    chk("fetch_resultsrc", 32'(ResultSrc), 2);

    run_instr(K_R, 3'b000, 1'b0, 1'b0, 0, 0, 7'h0, ncyc);
    chk("add_cycles", ncyc, 4);
    chk("add_aluc", 32'(cap_aluc), 3'b000);
    chk("add_regwrite", cap_rw, 1);
    chk("add_instret", instret, 1);
    run_instr(K_R, 3'b000, 1'b1, 1'b0, 0, 0, 7'h0, ncyc);
    chk("sub_aluc", 32'(cap_aluc), 3'b001);
    run_instr(K_LW, 3'b010, 1'b0, 1'b0, 0, 3, 7'h0, ncyc);
    chk("lw_cycles", ncyc, 8);
    chk("lw_regwrite", cap_rw, 1);
    chk("lw_instret", instret, 3);
    run_instr(K_SW, 3'b010, 1'b0, 1'b0, 0, 0, 7'h0, ncyc);
    chk("sw_cycles", ncyc, 4);
    chk("sw_regwrite", cap_rw, 0);
    chk("sw_immsrc", 32'(cap_imm), 2'b01);
    run_instr(K_BEQ, 3'b000, 1'b0, 1'b1, 0, 0, 7'h0, ncyc);
    chk("beq_taken_pcw", 32'(cap_pcw), 1);
    chk("beq_aluc", 32'(cap_aluc), 3'b001);
    chk("beq_immsrc", 32'(cap_imm), 2'b10);
    chk("beq_cycles", ncyc, 3);
    run_instr(K_BEQ, 3'b000, 1'b0, 1'b0, 0, 0, 7'h0, ncyc);
    chk("beq_not_taken_pcw", 32'(cap_pcw), 0);
    chk("beq_nt_cycles", ncyc, 3);
    run_instr(K_JAL, 3'b000, 1'b0, 1'b0, 0, 0, 7'h0, ncyc);
    chk("jal_cycles", ncyc, 4);
    chk("jal_regwrite", cap_rw, 1);
    chk("jal_immsrc", 32'(cap_imm), 2'b11);
    run_instr(K_ILL, 3'b000, 1'b0, 1'b0, 0, 0, 7'h7f, ncyc);
    chk("ill_cycles", ncyc, 2);
    chk("ill_pulses", cap_ill, 1);
    chk("ill_instret", instret, 7);

    // Reset asserted in the middle of a stalled store.
    start_instr(K_SW, 3'b010, 1'b0, 7'h0);
    zero = 1'b0;
    repeat (3) begin
      mem_ready = 1'b1;
      tick();
    end
    chk("sw_in_memwrite", 32'(state_o), P_MEMWRITE);
    mem_ready = 1'b0;
    #1;
    chk("pre_rst_memwrite", 32'(MemWrite), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_memwrite", 32'(MemWrite), 0);
    chk("midrst_mem_req", 32'(mem_req), 0);
    chk("midrst_state", 32'(state_o), P_FETCH);
    chk("midrst_instret", instret, 0);
    cur = P_FETCH;
    ph_q.delete();
    m_instret = '0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("held_rst_irwrite", 32'(IRWrite), 0);
    chk("held_rst_state", 32'(state_o), P_FETCH);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      run_instr($urandom_range(0, 6), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'b0, 1, 0, ill_ops[$urandom_range(0, 4)], ncyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv32i_multicycle_controller.md
Name: rv32i_multicycle_controller

Overview:
- Control FSM for the multi-cycle RV32I datapath. One ALU and one unified instruction/data memory are shared across the cycles of each instruction.
- Decodes opcode/funct3/funct7_5 and sequences the shared resources: fetch, decode, execute, memory access, writeback.
- Drives every datapath mux select and write enable, stalls on a memory-ready handshake, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instruction register [6:0].
- funct3  in  3  instruction register [14:12].
- funct7_5  in  1  instruction register [30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  store enable, valid while mem_req = 1.
- IRWrite  out  1  latch instruction register and OldPC.
- PCWrite  out  1  PC load enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- ImmSrc  out  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode.
- instret  out  CNT_W  retired-instruction count.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- State register and instret reset asynchronously: state = FETCH, instret = 0.
- While rst_n = 0, these outputs are forced to 0: mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal_instr.
- All outputs are Moore-decoded from state, except the mem_ready- and zero-qualified enables noted below.
- Any output not listed for a state is 0.
- ImmSrc is decoded from opcode in every state:
  - sw → 01; beq → 10; jal → 11; otherwise → 00.
- ALU decoder:
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 10, decode funct3:
    - 000: sub if opcode[5] & funct7_5, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - any other funct3: add.
- States, outputs and next state:
  - FETCH: mem_req = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10.
    - IRWrite = PCWrite = mem_ready.
    - Holds in FETCH until mem_ready = 1, then → DECODE.
  - DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 (branch target into ALUOut). Next state by opcode:
    - lw 0000011 or sw 0100011 → MEMADR.
    - R-type 0110011 → EXECR.
    - I-ALU 0010011 → EXECI.
    - beq 1100011 → BEQ.
    - jal 1101111 → JAL.
    - any other opcode → FETCH, with illegal_instr = 1 for this cycle and no architectural writes.
  - MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00. Next: lw → MEMREAD, sw → MEMWRITE.
  - MEMREAD: mem_req = 1, AdrSrc = 1. Holds until mem_ready = 1, then → MEMWB.
  - MEMWB: ResultSrc = 01, RegWrite = 1 → FETCH.
  - MEMWRITE: mem_req = 1, AdrSrc = 1, MemWrite = 1. Holds until mem_ready = 1, then → FETCH.
  - EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10 → ALUWB.
  - EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10 → ALUWB.
  - ALUWB: ResultSrc = 00, RegWrite = 1 → FETCH.
  - BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, PCWrite = zero → FETCH.
  - JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCWrite = 1 → ALUWB (writes PC+4 to rd).
- MemWrite stays asserted for the whole MEMWRITE stall; the memory commits on the mem_ready cycle.
- instret increments by 1 on each retirement, wrapping modulo 2^CNT_W. Retirement is any of:
  - leaving MEMWB or ALUWB;
  - leaving MEMWRITE with mem_ready = 1;
  - leaving BEQ.
- Illegal opcodes do not retire.
- Nominal cycle counts with zero wait states:
  - lw 5; sw 4; R/I 4; beq 3; jal 4.
- Each cycle that mem_ready = 0 while in FETCH/MEMREAD/MEMWRITE adds one cycle to that instruction's count.
- Reset asserted mid-instruction aborts immediately; there is no partial writeback after release.
- Resuming from reset: the first rising edge after rst_n deasserts starts evaluating FETCH.

Test Plan:
- Reset, then release with mem_ready = 1 stuck: FETCH drives mem_req = 1, IRWrite = 1, PCWrite = 1, ALUSrcB = 10, ResultSrc = 10; next state_o = DECODE; instret = 0.
- add (0110011, funct3 000, funct7_5 0) with mem_ready = 1: 4 cycles. ALUWB asserts RegWrite = 1 with ALUControl = 000 in EXECR. Same test with funct7_5 = 1 → ALUControl = 001. instret = 1.
- lw with mem_ready low for 3 cycles in MEMREAD: MEMREAD holds 4 cycles with AdrSrc = 1; MEMWB asserts ResultSrc = 01, RegWrite = 1; total 8 cycles; instret increments once.
- sw with mem_ready = 1: MEMWRITE asserts MemWrite = 1, mem_req = 1, ImmSrc = 01; RegWrite never asserted; 4 cycles.
- beq: zero = 1 → PCWrite = 1 in BEQ; zero = 0 → PCWrite = 0. ALUControl = 001, ImmSrc = 10, 3 cycles each.
- jal: PCWrite = 1 in JAL, then RegWrite = 1 in ALUWB, ImmSrc = 11.
- Opcode 1111111: illegal_instr pulses for one cycle in DECODE, returns to FETCH, instret unchanged.
- rst_n pulled low during MEMWRITE: MemWrite and mem_req drop to 0 immediately and state_o = FETCH.
